// File: rtl/sdram_phy.sv
// sdram_phy: registered SDRAM pin interface with CAS-latency-aligned read capture.
// Define SDRAM_PHY_CONFLICT_EN to build the sticky write/read bus-contention detector.
module sdram_phy #(
  parameter int AWIDTH        = 12,
  parameter int BWIDTH        = 2,
  parameter int DWIDTH        = 16,
  parameter int MWIDTH        = 2,
  parameter int CAS_LATENCY   = 2,
  parameter int BURST_LEN     = 1,
  parameter int CAPTURE_DELAY = 0,
  parameter int CLK_INVERT    = 0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              pin_clk,
  output logic              pin_cke,
  output logic              pin_cs_n,
  output logic              pin_ras_n,
  output logic              pin_cas_n,
  output logic              pin_we_n,
  output logic [BWIDTH-1:0] pin_ba,
  output logic [AWIDTH-1:0] pin_addr,
  output logic [MWIDTH-1:0] pin_dqm,
  inout  wire  [DWIDTH-1:0] pin_data,
  input  logic              cmd_cs_n,
  input  logic              cmd_ras_n,
  input  logic              cmd_cas_n,
  input  logic              cmd_we_n,
  input  logic [BWIDTH-1:0] cmd_ba,
  input  logic [AWIDTH-1:0] cmd_addr,
  input  logic [MWIDTH-1:0] cmd_dqm,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              wr_en,
  output logic [DWIDTH-1:0] rd_data,
  output logic              rd_valid,
  output logic              conflict
);
  localparam int RL = CAS_LATENCY + CAPTURE_DELAY + 2;
  localparam int PW = RL + BURST_LEN - 1;
  localparam logic [PW-1:0] RD_MASK = PW'((1 << BURST_LEN) - 1) << (RL - 1);
  if (CAS_LATENCY != 2 && CAS_LATENCY != 3) begin : g_bad_cl
    $error("sdram_phy: CAS_LATENCY must be 2 or 3");
  end
  if (BURST_LEN != 1 && BURST_LEN != 2 && BURST_LEN != 4 && BURST_LEN != 8) begin : g_bad_bl
    $error("sdram_phy: BURST_LEN must be 1, 2, 4 or 8");
  end
  if (CAPTURE_DELAY < 0 || CAPTURE_DELAY > 3) begin : g_bad_cd
    $error("sdram_phy: CAPTURE_DELAY must be 0..3");
  end
  logic              oe;
  logic [DWIDTH-1:0] dout;
  logic [PW-1:0]     rd_pipe;
  logic [DWIDTH-1:0] cap [CAPTURE_DELAY+1];
  logic              is_read;
  assign is_read  = !cmd_cs_n && cmd_ras_n && !cmd_cas_n && cmd_we_n;
  assign pin_clk  = (CLK_INVERT != 0) ? ~clk : clk;
  assign pin_data = oe ? dout : 'z;
  assign rd_valid = rd_pipe[0];
  assign rd_data  = cap[CAPTURE_DELAY];
  always_ff @(posedge clk) begin
    if (reset) begin
      pin_cke <= 1'b0;
      {pin_cs_n, pin_ras_n, pin_cas_n, pin_we_n} <= 4'hf;
      pin_ba   <= '0;
      pin_addr <= '0;
      pin_dqm  <= '1;
      oe       <= 1'b0;
      dout     <= '0;
      rd_pipe  <= '0;
    end else begin
      pin_cke <= 1'b1;
      {pin_cs_n, pin_ras_n, pin_cas_n, pin_we_n} <= {cmd_cs_n, cmd_ras_n, cmd_cas_n, cmd_we_n};
      pin_ba   <= cmd_ba;
      pin_addr <= cmd_addr;
      pin_dqm  <= cmd_dqm;
      oe       <= wr_en;
      if (wr_en) dout <= wr_data;
      // bit j set means a beat is due on rd_data j cycles from now; OR merges overlapping bursts
      rd_pipe  <= (rd_pipe >> 1) | (is_read ? RD_MASK : '0);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i <= CAPTURE_DELAY; i++) cap[i] <= '0;
    end else begin
      cap[0] <= pin_data;
      for (int i = 1; i <= CAPTURE_DELAY; i++) cap[i] <= cap[i-1];
    end
  end
`ifdef SDRAM_PHY_CONFLICT_EN
  // a beat due on rd_data CAPTURE_DELAY+1 cycles ahead is on the pins this cycle
  always_ff @(posedge clk) begin
    if (reset) conflict <= 1'b0;
    else if (oe && rd_pipe[CAPTURE_DELAY+1]) conflict <= 1'b1;
  end
`else
  assign conflict = 1'b0;
`endif
endmodule

// File: doc/sdram_phy.md
Name: sdram_phy

Overview:
- Registered SDRAM pin interface between the SDRAM controller and the device pins.
- Adds IO-registered command, address, bank and DQM outputs, and a registered tristate data path.
- Captures read data on a fixed pipeline delay derived from CAS latency, and tags read beats with a valid strobe across configurable bursts.
- Optionally detects write/read bus contention. Sits directly below the SDRAM controller, at the top-level pins.

Parameters:
- AWIDTH, 12, row/column address width.
- BWIDTH, 2, bank address width.
- DWIDTH, 16, data width.
- MWIDTH, 2, DQM width (DWIDTH/8).
- CAS_LATENCY, 2, device CAS latency in clocks (2 or 3).
- BURST_LEN, 1, read burst beats (1, 2, 4 or 8).
- CAPTURE_DELAY, 0, extra input capture stages (0..3) to absorb board delay.
- CLK_INVERT, 0. When 1, pin_clk is driven 180 degrees shifted (D0=0, D1=1 DDR output); otherwise D0=1, D1=0.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- pin_clk  out  1  SDRAM clock via DDR output register.
- pin_cke  out  1  clock enable.
- pin_cs_n, pin_ras_n, pin_cas_n, pin_we_n  out  1 each  registered command.
- pin_ba  out  BWIDTH  registered bank.
- pin_addr  out  AWIDTH  registered address.
- pin_dqm  out  MWIDTH  registered byte mask.
- pin_data  inout  DWIDTH  bidirectional data.
- cmd_cs_n, cmd_ras_n, cmd_cas_n, cmd_we_n  in  1 each  controller command.
- cmd_ba  in  BWIDTH  controller bank.
- cmd_addr  in  AWIDTH  controller address.
- cmd_dqm  in  MWIDTH  controller byte mask.
- wr_data  in  DWIDTH  write data.
- wr_en  in  1  drive wr_data on pins next cycle.
- rd_data  out  DWIDTH  captured read data.
- rd_valid  out  1  rd_data holds a read beat.
- conflict  out  1  sticky bus-contention flag.

Behaviour:
- Reset values (held while reset=1):
  - pin_cke=0, pin_cs_n=1, pin_ras_n=1, pin_cas_n=1, pin_we_n=1.
  - pin_ba=0, pin_addr=0, pin_dqm all-ones.
  - Data output enable=0 (pin_data high-Z).
  - rd_data=0, rd_valid=0, conflict=0, read-tracking pipeline cleared.
- pin_cke goes to 1 on the first clock after reset deasserts and stays 1. pin_clk toggles regardless of reset.
- Command path: every cmd_* input is registered once onto its pin_* output (1-cycle latency), unconditionally every cycle.
- Write path:
  - wr_en=1 at cycle t registers wr_data into the output register and sets output enable at t+1.
  - pin_data is driven only while the registered enable=1; otherwise high-Z.
  - Back-to-back wr_en keeps the enable high continuously, with no turnaround gap inserted.
- Read detection: a READ is cmd_cs_n=0, cmd_ras_n=1, cmd_cas_n=0, cmd_we_n=1, sampled at cycle t.
- Read latency:
  - pin_data is sampled every cycle into the input register, then passes through CAPTURE_DELAY further stages into rd_data.
  - The first beat of a READ at t appears on rd_data with rd_valid=1 at cycle t+RL, where RL = 1 + CAS_LATENCY + 1 + CAPTURE_DELAY.
  - rd_valid then stays high for BURST_LEN consecutive cycles.
- Read tracking:
  - Implemented as a valid shift pipeline.
  - Overlapping or back-to-back READs merge: a READ issued while a previous burst is still in flight extends rd_valid, with no gap and no double counting.
  - A new READ does not truncate an earlier burst.
- rd_data updates every cycle regardless of rd_valid. Consumers qualify data with rd_valid.
- Mid-operation reset clears the pipeline on the next edge; no rd_valid is emitted for reads issued before reset.
- BURST_LEN or CAS_LATENCY outside the legal set is a synthesis-time error (generate-time $error).

Optional Feature:
- Macro SDRAM_PHY_CONFLICT_EN.
- Defined: conflict is set to 1 when the registered output enable is 1 in any cycle where the read pipeline expects a returning beat at the pins. That window is the cycles in which the device drives the bus, i.e. t+1+CAS_LATENCY .. t+CAS_LATENCY+BURST_LEN for each READ at t.
- conflict stays 1 until reset.
- Not defined: conflict is tied to 0 and no detection logic is built.

Test Plan:
- Reset held 5 cycles, then released → during reset pins show NOP, cke=0, dqm=all-ones, pin_data high-Z, rd_valid=0. pin_cke=1 on the first cycle after release.
- CAS_LATENCY=2, CAPTURE_DELAY=0, BURST_LEN=1: READ at cycle 10, device model returns 16'hA5C3 → rd_valid=1 only at cycle 14, with rd_data=16'hA5C3.
- BURST_LEN=4, CAS_LATENCY=3: READs at cycles 20 and 24 → rd_valid high cycles 25..32 continuously; the device model's 8 beats (16'h0001..16'h0008) appear in order.
- wr_en=1 at cycles 40..42 with data 16'h1111/16'h2222/16'h3333 → pin_data shows those values at cycles 41..43; high-Z at 44.
- SDRAM_PHY_CONFLICT_EN defined, CAS_LATENCY=2: READ at 50, wr_en=1 at 52 → enable high at 53, which falls in the return window 53..53 → conflict=1 from 54 and stays 1 until reset. Without the macro, conflict stays 0.
- Reset asserted at cycle 61 after a READ at cycle 60 (CAS_LATENCY=2) → rd_valid never asserts for that read.
